// File: rtl/pf_lanectrl_pause_sync_mc.sv
// Multi-lane HS_IO_CLK_PAUSE synchroniser / stretcher.
// Each lane resynchronises an asynchronous pause request into CLK. It then
// stretches the request to a minimum width and enforces a minimum low gap
// between pauses. A request that arrives during that gap is remembered and
// turned into exactly one further pause. The output can optionally be
// retimed on the falling CLK edge.
module pf_lanectrl_pause_sync_mc #(
    parameter int NUM_LANES        = 4,
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_PAUSE_CYCLES = 3,
    parameter int HOLDOFF_CYCLES   = 2,
    parameter bit OUT_NEG_EDGE     = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
    output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
    output logic                 PAUSE_ACTIVE_ANY
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAUSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Counter reload values. The counter counts down to 0, so a reload of N-1
    // gives N cycles.
    localparam logic [3:0] MIN_RELOAD  = 4'(MIN_PAUSE_CYCLES - 1);
    localparam logic [3:0] HOLD_RELOAD = 4'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam bit         HAS_HOLDOFF = (HOLDOFF_CYCLES > 0);

    // Reject illegal builds at elaboration time.
    if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_num_lanes
        $error("NUM_LANES must be 1..16");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be 0..4");
    end
    if (MIN_PAUSE_CYCLES < 1 || MIN_PAUSE_CYCLES > 15) begin : g_bad_min_pause
        $error("MIN_PAUSE_CYCLES must be 1..15");
    end
    if (HOLDOFF_CYCLES < 0 || HOLDOFF_CYCLES > 15) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be 0..15");
    end

    logic [NUM_LANES-1:0] req_sync;   // synchronised request seen by the FSMs
    logic [NUM_LANES-1:0] out_vec;    // posedge output registers of all lanes

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign req_sync = HS_IO_CLK_PAUSE;
    end else begin : g_sync
        logic [NUM_LANES-1:0] sync_q [SYNC_STAGES];

        // Metastability chain: the request is shifted one stage per rising edge.
        // NOTE: state registers use non-blocking assignments. Every flop then
        // samples the value from before the edge, so the chain shifts by one
        // stage per clock instead of collapsing into a single flop.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
                sync_q[0] <= HS_IO_CLK_PAUSE;
                for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
        end

        assign req_sync = sync_q[SYNC_STAGES-1];
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        state_t     state_q, state_d;
        logic [3:0] cnt_q, cnt_d;
        logic       pnd_q, pnd_d;
        logic       out_q, out_d;

        // Per-lane state, counter, pending flag and output register.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pnd_q   <= 1'b0;
                out_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pnd_q   <= pnd_d;
                out_q   <= out_d;
            end
        end

        // Next state: stretch to the minimum width, then hold off. A request
        // seen during hold-off is latched in pnd so that it starts one more pause.
        // NOTE: every signal is given its hold value first. Branches that do
        // not assign a signal then cannot leave it unassigned and infer a latch.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pnd_d   = pnd_q;
            out_d   = out_q;
            unique case (state_q)
                ST_IDLE: begin
                    out_d = 1'b0;
                    if (req_sync[l]) begin
                        state_d = ST_PAUSE;
                        out_d   = 1'b1;
                        cnt_d   = MIN_RELOAD;
                    end
                end
                ST_PAUSE: begin
                    out_d = 1'b1;
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (!req_sync[l]) begin
                        out_d = 1'b0;
                        if (HAS_HOLDOFF) begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = HOLD_RELOAD;
                            pnd_d   = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    out_d = 1'b0;
                    if (req_sync[l]) pnd_d = 1'b1;
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (pnd_q || req_sync[l]) begin
                        state_d = ST_PAUSE;
                        out_d   = 1'b1;
                        cnt_d   = MIN_RELOAD;
                        pnd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        pnd_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                    pnd_d   = 1'b0;
                end
            endcase
        end

        assign out_vec[l] = out_q;
    end

    if (OUT_NEG_EDGE) begin : g_neg_out
        logic [NUM_LANES-1:0] out_n;

        // Retime the outputs half a cycle later, on the falling edge.
        always_ff @(negedge CLK or posedge RESET) begin
            if (RESET) out_n <= '0;
            else       out_n <= out_vec;
        end

        assign HS_IO_CLK_PAUSE_SYNC = out_n;
    end else begin : g_pos_out
        assign HS_IO_CLK_PAUSE_SYNC = out_vec;
    end

    assign PAUSE_ACTIVE_ANY = |HS_IO_CLK_PAUSE_SYNC;

endmodule
